ckt_equiv_eval: RTL and testbench

- Registered evaluator for one 11-input, 1-output Boolean function.
- Holds two implementations of the function: "org", an unfactored multi-level netlist, and "sim", the minimized netlist.
- Compares the two on every evaluated vector.
- Has a built-in exhaustive self-sweep over all 2^11 vectors that counts mismatches. The block sits beside the MFFC simplification flow as the equivalence gate between original and simplified logic.

---
 rtl/ckt_equiv_pkg.sv | 12 +
 rtl/ckt_equiv_eval_pair.sv | 20 ++
 rtl/ckt_equiv_eval.sv | 63 ++++++
 tb/tb_ckt_equiv_eval.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ckt_equiv_pkg.sv
// ckt_equiv_pkg: shared constants, sweep states and the reference function for ckt_equiv_eval
package ckt_equiv_pkg;
    localparam int M = 11;
    localparam int NVEC = 2048;
    localparam int CNT_W = 12;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic f_ref(input logic [M-1:0] x);
        return (((x[10] & x[9]) | (x[8] ^ x[7])) & ~(x[6] & x[5] & x[4])) | (x[3] & x[2] & (x[1] | x[0]));
    endfunction
endpackage

// File: rtl/ckt_equiv_eval_pair.sv
// ckt_func_pair: unfactored (org) and factored (sim) netlists of the same 11-input function
module ckt_func_pair
    import ckt_equiv_pkg::*;
(
    input  logic [M-1:0] vec,
    output logic         org,
    output logic         sim
);
    logic [M-1:0] x;
    assign x = vec;

    // flat sum of products; the last product is subsumed by x8 & ~x7 & ~x6 and kept on purpose
    assign org = (x[10] & x[9] & ~x[6]) | (x[10] & x[9] & ~x[5]) | (x[10] & x[9] & ~x[4])
               | (x[8] & ~x[7] & ~x[6]) | (x[8] & ~x[7] & ~x[5]) | (x[8] & ~x[7] & ~x[4])
               | (~x[8] & x[7] & ~x[6]) | (~x[8] & x[7] & ~x[5]) | (~x[8] & x[7] & ~x[4])
               | (x[3] & x[2] & x[1]) | (x[3] & x[2] & x[0])
               | (x[10] & x[9] & x[8] & ~x[7] & ~x[6]);

    assign sim = (((x[10] & x[9]) | (x[8] ^ x[7])) & ~(x[6] & x[5] & x[4])) | (x[3] & x[2] & (x[1] | x[0]));
endmodule

// File: rtl/ckt_equiv_eval.sv
// ckt_equiv_eval: registered org/sim comparison with an exhaustive self-sweep mismatch counter
module ckt_equiv_eval
    import ckt_equiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [M-1:0]     in_vec,
    input  logic             in_valid,
    input  logic             sweep_start,
    output logic             y_org,
    output logic             y_sim,
    output logic             out_valid,
    output logic             mismatch,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [CNT_W-1:0] err_count
);
    state_t       state;
    logic [M-1:0] cnt;
    logic [M-1:0] vec;
    logic         org, sim, start, acc;

    // a sweep request beats a simultaneous external vector
    assign start = (state == IDLE) && sweep_start;
    assign acc = (state == RUN) || ((state == IDLE) && in_valid && !sweep_start);
    assign vec = (state == RUN) ? cnt : in_vec;
    assign sweep_busy = state != IDLE;

    ckt_func_pair u_pair (.vec(vec), .org(org), .sim(sim));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            err_count <= '0;
            y_org <= 1'b0;
            y_sim <= 1'b0;
            mismatch <= 1'b0;
            out_valid <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            out_valid <= acc;
            sweep_done <= 1'b0;
            if (acc) begin
                y_org <= org;
                y_sim <= sim;
                mismatch <= org ^ sim;
            end
            if (start) begin
                state <= RUN;
                cnt <= '0;
                err_count <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                err_count <= err_count + {{(CNT_W-1){1'b0}}, org ^ sim};
                if (cnt == M'(NVEC - 1)) state <= DRAIN;
            end else if (state == DRAIN) begin
                state <= IDLE;
                sweep_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ckt_equiv_eval.sv
// tb_ckt_equiv_eval: random and directed checks of ckt_equiv_eval against a bit-field model of f
module tb_ckt_equiv_eval;
    import ckt_equiv_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sweep_start = 1'b0;
    logic [10:0] in_vec = '0;
    logic        y_org, y_sim, out_valid, mismatch, sweep_busy, sweep_done;
    logic [11:0] err_count;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    ckt_equiv_eval dut (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .sweep_start(sweep_start),
        .y_org(y_org), .y_sim(y_sim), .out_valid(out_valid), .mismatch(mismatch),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // f read as field tests on the integer vector
    function automatic bit fm(input int x);
        bit a, b, c, d;
        a = ((x >> 9) & 3) == 3;
        b = ((x >> 7) & 3) == 1 || ((x >> 7) & 3) == 2;
        c = ((x >> 4) & 7) != 7;
        d = ((x >> 2) & 3) == 3 && (x & 3) != 0;
        return ((a || b) && c) || d;
    endfunction

    task automatic run_sweep(input bit inject, input bit collide, input int abort_at);
        int nres = 0, ndone = 0;
        bit e, mm, aborted = 0;
        logic [11:0] errs = '0;
        in_valid = 1'b0;
        @(negedge clk);
        sweep_start = 1'b1; in_valid = collide; in_vec = 11'h600;
        @(negedge clk);
        sweep_start = 1'b0;
        check("busy", sweep_busy, 1);
        check("err_clr", err_count, 0);
        check("first_ov", out_valid, 0);
        for (int iss = 0; iss < 2056; iss++) begin
            if (out_valid) begin
                e = fm(nres);
                mm = inject && (nres == 5 || nres == 2047);
                check("sw_org", y_org, e);
                check("sw_sim", y_sim, e ^ mm);
                check("sw_mm", mismatch, mm);
                errs += mm;
                nres++;
            end
            if (sweep_done) begin
                ndone++;
                check("done_after_last", nres, 2048);
                check("ov_at_done", out_valid, 0);
            end
            if (nres == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_outs", {y_org, y_sim, out_valid, mismatch, sweep_busy, sweep_done}, 0);
                check("rst_err", err_count, 0);
                in_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            sweep_start = collide && iss == 5;
            in_valid = iss < 2040 ? 1'($urandom) : 1'b0;
            in_vec = 11'($urandom);
            if (inject && iss == 5) force dut.sim = 1'b1;
            else if (inject && iss == 2047) force dut.sim = 1'b0;
            else if (inject) release dut.sim;
            @(negedge clk);
        end
        if (aborted) begin
            check("abort_ndone", ndone, 0);
            check("abort_err", err_count, 0);
            check("abort_idle", sweep_busy, 0);
        end else begin
            check("nres", nres, 2048);
            check("ndone", ndone, 1);
            check("err_count", err_count, errs);
            check("idle", sweep_busy, 0);
        end
    endtask

    initial begin
        logic [10:0] dv [6] = '{11'h000, 11'h600, 11'h670, 11'h00D, 11'h100, 11'h180};
        bit          de [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bit          pv, pe, last_e;
        int          bad = 0;
        @(negedge clk);
        check("rst_outs0", {y_org, y_sim, out_valid, mismatch, sweep_busy, sweep_done}, 0);
        check("rst_err0", err_count, 0);
        rst_n = 1'b1;
        for (int v = 0; v < 2048; v++) if (f_ref(11'(v)) != fm(v)) bad++;
        check("pkg_f", bad, 0);
        for (int i = 0; i < 6; i++) begin
            in_vec = dv[i]; in_valid = 1'b1;
            @(negedge clk);
            check("dir_org", y_org, de[i]);
            check("dir_sim", y_sim, de[i]);
            check("dir_ov", out_valid, 1);
            check("dir_mm", mismatch, 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_ov", out_valid, 0);
        check("hold_org", y_org, de[5]);
        last_e = de[5];
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom); in_vec = 11'($urandom);
            pv = in_valid; pe = fm(in_vec);
            @(negedge clk);
            check("rnd_ov", out_valid, pv);
            if (pv) last_e = pe;
            check("rnd_org", y_org, last_e);
            check("rnd_sim", y_sim, last_e);
            check("rnd_mm", mismatch, 0);
        end
        run_sweep(1, 0, -1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_vec = 11'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("err_hold", err_count, 2);
        run_sweep(0, 0, -1);
        run_sweep(0, 1, -1);
        run_sweep(0, 0, 1000);
        run_sweep(0, 0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
